// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - hazard, forwarding and data-memory wait sequencing for a 5-stage RV32I pipeline
// Combinational stage controls from state and hazards; wait/timeout FSM and saturating stall counter.
module pipeline_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [4:0]       ID_RS1,
  input  logic [4:0]       ID_RS2,
  input  logic             ID_USE_RS1,
  input  logic             ID_USE_RS2,
  input  logic [4:0]       EX_RS1,
  input  logic [4:0]       EX_RS2,
  input  logic [4:0]       EX_RD,
  input  logic             EX_MEMRD,
  input  logic             EX_TAKEN,
  input  logic [4:0]       MEM_RD,
  input  logic             MEM_REGWRT,
  input  logic [4:0]       WB_RD,
  input  logic             WB_REGWRT,
  input  logic             DMEM_REQ,
  input  logic             DMEM_READY,
  output logic             PC_EN,
  output logic             IF_ID_EN,
  output logic             ID_EX_EN,
  output logic             EX_MEM_EN,
  output logic             MEM_WB_EN,
  output logic             IF_ID_FLUSH,
  output logic             ID_EX_FLUSH,
  output logic [1:0]       FWD_A,
  output logic [1:0]       FWD_B,
  output logic             MEM_ERR,
  output logic [CNT_W-1:0] STALL_CNT
);

  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_INIT     = 2'd0,
    S_RUN      = 2'd1,
    S_MEM_WAIT = 2'd2,
    S_ERR      = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] to_cnt, to_cnt_nxt;
  logic          err_set;
  logic          freeze, taken, loaduse, stall_inc;

  assign freeze  = DMEM_REQ & ~DMEM_READY;
  assign taken   = EX_TAKEN;
  assign loaduse = EX_MEMRD & (EX_RD != 5'd0) &
                   ((ID_USE_RS1 & (ID_RS1 == EX_RD)) | (ID_USE_RS2 & (ID_RS2 == EX_RD)));

  // MEM wins over WB because it holds the younger result; x0 is hardwired zero.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] mem_rd, input logic mem_wr,
                                         input logic [4:0] wb_rd,  input logic wb_wr);
    if (mem_wr && (mem_rd != 5'd0) && (mem_rd == rs))
      return 2'b10;
    else if (wb_wr && (wb_rd != 5'd0) && (wb_rd == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign FWD_A = fwd_sel(EX_RS1, MEM_RD, MEM_REGWRT, WB_RD, WB_REGWRT);
  assign FWD_B = fwd_sel(EX_RS2, MEM_RD, MEM_REGWRT, WB_RD, WB_REGWRT);

  always_comb begin
    state_nxt   = state;
    to_cnt_nxt  = to_cnt;
    err_set     = 1'b0;
    PC_EN       = 1'b0;
    IF_ID_EN    = 1'b0;
    ID_EX_EN    = 1'b0;
    EX_MEM_EN   = 1'b0;
    MEM_WB_EN   = 1'b0;
    IF_ID_FLUSH = 1'b0;
    ID_EX_FLUSH = 1'b0;
    case (state)
      S_INIT: begin
        IF_ID_FLUSH = 1'b1;
        ID_EX_FLUSH = 1'b1;
        state_nxt   = S_RUN;
      end
      S_RUN, S_MEM_WAIT: begin
        if (freeze) begin
          if (state == S_RUN) begin
            state_nxt  = S_MEM_WAIT;
            to_cnt_nxt = '0;
          end else if (to_cnt == TO_LAST) begin
            state_nxt = S_ERR;
            err_set   = 1'b1;
          end else begin
            to_cnt_nxt = to_cnt + 1'b1;
          end
        end else begin
          state_nxt  = S_RUN;
          to_cnt_nxt = '0;
          PC_EN      = 1'b1;
          IF_ID_EN   = 1'b1;
          ID_EX_EN   = 1'b1;
          EX_MEM_EN  = 1'b1;
          MEM_WB_EN  = 1'b1;
          // A redirect squashes the dependent instruction anyway, so it outranks load-use.
          if (taken) begin
            IF_ID_FLUSH = 1'b1;
            ID_EX_FLUSH = 1'b1;
          end else if (loaduse) begin
            PC_EN       = 1'b0;
            IF_ID_EN    = 1'b0;
            ID_EX_FLUSH = 1'b1;
          end
        end
      end
      S_ERR: begin
        state_nxt = S_ERR;
      end
      default: begin
        state_nxt = S_INIT;
      end
    endcase
  end

  assign stall_inc = ((state == S_RUN) || (state == S_MEM_WAIT)) && !PC_EN;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_INIT;
      to_cnt    <= '0;
      MEM_ERR   <= 1'b0;
      STALL_CNT <= '0;
    end else begin
      state  <= state_nxt;
      to_cnt <= to_cnt_nxt;
      if (err_set)
        MEM_ERR <= 1'b1;
      if (stall_inc && (STALL_CNT != {CNT_W{1'b1}}))
        STALL_CNT <= STALL_CNT + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - self-checking bench for pipeline_ctrl
// Vector table, directed multi-cycle sequences and random stimulus against a behavioural model.
module tb_pipeline_ctrl;

  localparam int TO  = 4;
  localparam int CW  = 5;
  localparam int MAXS = (1 << CW) - 1;

  typedef struct packed {
    logic [4:0] id_rs1, id_rs2;
    logic       id_u1, id_u2;
    logic [4:0] ex_rs1, ex_rs2, ex_rd;
    logic       ex_ld, ex_tk;
    logic [4:0] mem_rd;
    logic       mem_w;
    logic [4:0] wb_rd;
    logic       wb_w;
    logic       req, rdy;
  } in_t;

  typedef struct packed {
    logic [4:0]    en;
    logic [1:0]    fl;
    logic [1:0]    fa, fb;
    logic          err;
    logic [CW-1:0] stall;
  } out_t;

  typedef struct {
    in_t        i;
    logic [4:0] en;
    logic [1:0] fl, fa, fb;
  } vec_t;

  logic CLK = 1'b0;
  logic RST_N;
  in_t  cur;
  out_t act;

  logic PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN, IF_ID_FLUSH, ID_EX_FLUSH, MEM_ERR;
  logic [1:0]    FWD_A, FWD_B;
  logic [CW-1:0] STALL_CNT;

  always #5 CLK = ~CLK;

  pipeline_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .ID_RS1(cur.id_rs1), .ID_RS2(cur.id_rs2), .ID_USE_RS1(cur.id_u1), .ID_USE_RS2(cur.id_u2),
    .EX_RS1(cur.ex_rs1), .EX_RS2(cur.ex_rs2), .EX_RD(cur.ex_rd),
    .EX_MEMRD(cur.ex_ld), .EX_TAKEN(cur.ex_tk),
    .MEM_RD(cur.mem_rd), .MEM_REGWRT(cur.mem_w), .WB_RD(cur.wb_rd), .WB_REGWRT(cur.wb_w),
    .DMEM_REQ(cur.req), .DMEM_READY(cur.rdy),
    .PC_EN(PC_EN), .IF_ID_EN(IF_ID_EN), .ID_EX_EN(ID_EX_EN), .EX_MEM_EN(EX_MEM_EN),
    .MEM_WB_EN(MEM_WB_EN), .IF_ID_FLUSH(IF_ID_FLUSH), .ID_EX_FLUSH(ID_EX_FLUSH),
    .FWD_A(FWD_A), .FWD_B(FWD_B), .MEM_ERR(MEM_ERR), .STALL_CNT(STALL_CNT)
  );

  assign act = {PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN, IF_ID_FLUSH, ID_EX_FLUSH,
                FWD_A, FWD_B, MEM_ERR, STALL_CNT};

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: 0 init, 1 run, 2 waiting on memory, 3 error.
  int m_mode, m_wait, m_stall;
  bit m_err;

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    n_total++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, a, e);
  endtask

  function automatic in_t mk(input logic [4:0] id_rs1, id_rs2, input logic u1, u2,
                             input logic [4:0] ex_rs1, ex_rs2, ex_rd, input logic ld, tk,
                             input logic [4:0] mem_rd, input logic mw,
                             input logic [4:0] wb_rd, input logic ww, input logic req, rdy);
    in_t r;
    r = '{id_rs1, id_rs2, u1, u2, ex_rs1, ex_rs2, ex_rd, ld, tk, mem_rd, mw, wb_rd, ww, req, rdy};
    return r;
  endfunction

  function automatic logic [1:0] m_fwd(input in_t i, input logic [4:0] rs);
    if (rs == 0) return 2'b00;
    if (i.mem_w && i.mem_rd == rs) return 2'b10;
    if (i.wb_w && i.wb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic out_t model_out(input in_t i);
    out_t o;
    bit   reads_load;
    reads_load = i.ex_ld && i.ex_rd != 0 &&
                 ((i.id_u1 && i.id_rs1 == i.ex_rd) || (i.id_u2 && i.id_rs2 == i.ex_rd));
    o.fa = m_fwd(i, i.ex_rs1);
    o.fb = m_fwd(i, i.ex_rs2);
    o.err = m_err;
    o.stall = CW'(m_stall);
    o.en = 5'b00000;
    o.fl = 2'b00;
    if (m_mode == 0) o.fl = 2'b11;
    else if (m_mode == 1 || m_mode == 2) begin
      if (i.req && !i.rdy) o.en = 5'b00000;
      else if (i.ex_tk) begin o.en = 5'b11111; o.fl = 2'b11; end
      else if (reads_load) begin o.en = 5'b00111; o.fl = 2'b01; end
      else o.en = 5'b11111;
    end
    return o;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_wait = 0; m_stall = 0; m_err = 0;
  endtask

  task automatic model_tick(input in_t i, input logic pc_en);
    bit frozen;
    frozen = i.req && !i.rdy;
    if ((m_mode == 1 || m_mode == 2) && !pc_en && m_stall < MAXS) m_stall++;
    case (m_mode)
      0: m_mode = 1;
      1: if (frozen) begin m_mode = 2; m_wait = 0; end
      2: if (!frozen) begin m_mode = 1; m_wait = 0; end
         else if (m_wait == TO - 1) begin m_mode = 3; m_err = 1; end
         else m_wait++;
      default: ;
    endcase
  endtask

  task automatic step(input logic rst, input in_t i, input string tag, output out_t a);
    out_t e;
    RST_N = rst;
    cur = i;
    if (!rst) model_reset();
    @(negedge CLK);
    e = model_out(i);
    a = act;
    chk({tag, ".en"}, 32'(a.en), 32'(e.en));
    chk({tag, ".flush"}, 32'(a.fl), 32'(e.fl));
    chk({tag, ".fwd_a"}, 32'(a.fa), 32'(e.fa));
    chk({tag, ".fwd_b"}, 32'(a.fb), 32'(e.fb));
    chk({tag, ".mem_err"}, 32'(a.err), 32'(e.err));
    chk({tag, ".stall_cnt"}, 32'(a.stall), 32'(e.stall));
    if (rst) model_tick(i, e.en[4]);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    out_t a;
    in_t  z, fr, rl, lu;
    int   s0;

    z  = mk(0,0,0,0, 0,0,0,0,0, 0,0, 0,0, 0,1);
    fr = mk(0,0,0,0, 0,0,0,0,0, 0,0, 0,0, 1,0);
    rl = mk(0,0,0,0, 0,0,0,0,0, 0,0, 0,0, 1,1);
    lu = mk(5,7,1,1, 0,0,5,1,0, 0,0, 0,0, 0,1);

    // inputs, en {pc,if_id,id_ex,ex_mem,mem_wb}, flush {if_id,id_ex}, fwd_a, fwd_b
    tbl.push_back('{z,                                         5'b11111, 2'b00, 2'b00, 2'b00});
    tbl.push_back('{mk(5,7,1,1, 0,0,5,1,0, 0,0, 0,0, 0,1),     5'b00111, 2'b01, 2'b00, 2'b00});
    tbl.push_back('{mk(0,7,1,1, 0,0,0,1,0, 0,0, 0,0, 0,1),     5'b11111, 2'b00, 2'b00, 2'b00});
    tbl.push_back('{mk(1,9,1,1, 0,0,9,1,0, 0,0, 0,0, 0,1),     5'b00111, 2'b01, 2'b00, 2'b00});
    tbl.push_back('{mk(1,9,1,0, 0,0,9,1,0, 0,0, 0,0, 0,1),     5'b11111, 2'b00, 2'b00, 2'b00});
    tbl.push_back('{mk(5,7,1,0, 0,0,5,0,0, 0,0, 0,0, 0,1),     5'b11111, 2'b00, 2'b00, 2'b00});
    tbl.push_back('{mk(5,7,1,1, 0,0,5,1,1, 0,0, 0,0, 0,1),     5'b11111, 2'b11, 2'b00, 2'b00});
    tbl.push_back('{mk(0,0,0,0, 3,3,0,0,0, 3,1, 3,1, 0,1),     5'b11111, 2'b00, 2'b10, 2'b10});
    tbl.push_back('{mk(0,0,0,0, 3,3,0,0,0, 3,0, 3,1, 0,1),     5'b11111, 2'b00, 2'b01, 2'b01});
    tbl.push_back('{mk(0,0,0,0, 0,0,0,0,0, 0,1, 0,1, 0,1),     5'b11111, 2'b00, 2'b00, 2'b00});
    tbl.push_back('{mk(0,0,0,0, 4,7,0,0,0, 4,1, 7,1, 0,1),     5'b11111, 2'b00, 2'b10, 2'b01});
    tbl.push_back('{mk(0,0,0,0, 4,7,0,0,0, 7,1, 4,1, 0,1),     5'b11111, 2'b00, 2'b01, 2'b10});

    // Reset release: one bubble cycle, then free running.
    model_reset();
    step(0, z, "rst0", a);
    step(0, z, "rst1", a);
    step(1, z, "init", a);
    chk("init_enables", 32'(a.en), 32'h00);
    chk("init_flushes", 32'(a.fl), 32'h3);
    step(1, z, "run0", a);
    chk("run0_enables", 32'(a.en), 32'h1f);
    chk("run0_stall", 32'(a.stall), 32'h0);

    foreach (tbl[k]) begin
      step(1, tbl[k].i, $sformatf("vec%0d", k), a);
      chk($sformatf("vec%0d.tbl_en", k), 32'(a.en), 32'(tbl[k].en));
      chk($sformatf("vec%0d.tbl_flush", k), 32'(a.fl), 32'(tbl[k].fl));
      chk($sformatf("vec%0d.tbl_fwd_a", k), 32'(a.fa), 32'(tbl[k].fa));
      chk($sformatf("vec%0d.tbl_fwd_b", k), 32'(a.fb), 32'(tbl[k].fb));
    end
    step(1, z, "after_tbl", a);
    chk("tbl_stall_total", 32'(a.stall), 32'd2);

    // Three frozen cycles, then released on the fourth.
    step(1, fr, "wait0", a);
    s0 = int'(a.stall);
    step(1, fr, "wait1", a);
    step(1, fr, "wait2", a);
    chk("wait_enables", 32'(a.en), 32'h00);
    step(1, rl, "wait_rel", a);
    chk("wait_rel_enables", 32'(a.en), 32'h1f);
    chk("wait_stall_plus3", 32'(a.stall), 32'(s0 + 3));
    step(1, z, "wait_run", a);

    // Held frozen until timeout; error is sticky and ignores DMEM_READY.
    for (int k = 0; k < 8; k++) step(1, fr, $sformatf("to%0d", k), a);
    chk("timeout_err", 32'(a.err), 32'h1);
    for (int k = 0; k < 3; k++) step(1, rl, $sformatf("err%0d", k), a);
    chk("err_sticky", 32'(a.err), 32'h1);
    chk("err_enables", 32'(a.en), 32'h00);
    step(0, z, "err_rst", a);
    chk("err_cleared", 32'(a.err), 32'h0);
    step(1, z, "err_init", a);
    step(1, z, "err_run", a);

    // Reset in the middle of a memory wait.
    step(1, fr, "mw0", a);
    step(1, fr, "mw1", a);
    step(0, fr, "mw_rst", a);
    chk("mw_rst_flush", 32'(a.fl), 32'h3);
    step(1, z, "mw_init", a);
    step(1, z, "mw_run", a);

    // Continuous load-use stalls saturate the counter.
    for (int k = 0; k < MAXS + 8; k++) step(1, lu, $sformatf("sat%0d", k), a);
    chk("stall_saturated", 32'(a.stall), 32'(MAXS));

    step(0, z, "rnd_rst", a);
    for (int k = 0; k < 400; k++) begin
      in_t r;
      logic rs;
      r.id_rs1 = 5'($urandom_range(0, 3)); r.id_rs2 = 5'($urandom_range(0, 3));
      r.id_u1 = 1'($urandom);  r.id_u2 = 1'($urandom);
      r.ex_rs1 = 5'($urandom_range(0, 3)); r.ex_rs2 = 5'($urandom_range(0, 3));
      r.ex_rd = 5'($urandom_range(0, 3));
      r.ex_ld = 1'($urandom);  r.ex_tk = ($urandom_range(0, 3) == 0);
      r.mem_rd = 5'($urandom_range(0, 3)); r.mem_w = 1'($urandom);
      r.wb_rd = 5'($urandom_range(0, 3));  r.wb_w = 1'($urandom);
      r.req = ($urandom_range(0, 2) == 0); r.rdy = ($urandom_range(0, 2) != 0);
      rs = !($urandom_range(0, 60) == 0 || (m_mode == 3 && $urandom_range(0, 4) == 0));
      step(rs, r, $sformatf("rnd%0d", k), a);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
